// File: rtl/updown_tick_counter_if.sv
// Signal bundle between the up/down tick counter and its surroundings:
// switch/load/enable controls in, count and status pulses out.
interface updown_tick_counter_if #(
   parameter int WIDTH = 8
) ();
   logic             en;
   logic             UD;
   logic             load;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] q;
   logic             tick;
   logic             tc;
   logic             dir;

   modport master (
      output en, UD, load, din,
      input  q, tick, tc, dir
   );

   modport slave (
      input  en, UD, load, din,
      output q, tick, tc, dir
   );
endinterface

// File: rtl/updown_tick_counter.sv
// Parametrised up/down counter advanced by a prescaled tick, with a
// debounced direction switch, synchronous load and wrap/saturate limits.
module updown_tick_counter #(
   parameter int WIDTH      = 8,
   parameter int MAX        = 255,
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 1,
   parameter bit SAT        = 1'b0,
   parameter int DEB_CYCLES = 1_000_000
) (
   input logic                  clk,
   input logic                  reset,
   updown_tick_counter_if.slave bus
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DCW = $clog2(DEB_CYCLES + 1);

   localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
   localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEB_CYCLES - 1);
   localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MAX);

   typedef enum logic {
      STABLE   = 1'b0,
      CHANGING = 1'b1
   } deb_state_t;

   logic [PW-1:0]    pre;
   logic             tick_event;
   logic             tick_q;

   logic             s_meta;
   logic             s_sync;

   deb_state_t       deb_state, deb_state_nxt;
   logic [DCW-1:0]   deb_cnt, deb_cnt_nxt;
   logic             dir_q, dir_nxt;

   logic [WIDTH-1:0] q, q_nxt;
   logic             tc_q, tc_nxt;

   // ---------------------------------------------------------------
   // Prescaler: phase is held while disabled, so a pause only stretches
   // the current period.
   // ---------------------------------------------------------------
   assign tick_event = bus.en && (pre == PRE_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre    <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_event;
         if (tick_event) begin
            pre <= '0;
         end else if (bus.en) begin
            pre <= pre + 1'b1;
         end
      end
   end

   // Two-flop synchroniser for the asynchronous direction switch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_meta <= 1'b0;
         s_sync <= 1'b0;
      end else begin
         s_meta <= bus.UD;
         s_sync <= s_meta;
      end
   end

   // ---------------------------------------------------------------
   // Debouncer: dir follows s only after s has differed from it for
   // DEB_CYCLES consecutive clocks.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_state <= STABLE;
         deb_cnt   <= '0;
         dir_q     <= 1'b0;
      end else begin
         deb_state <= deb_state_nxt;
         deb_cnt   <= deb_cnt_nxt;
         dir_q     <= dir_nxt;
      end
   end

   // NOTE: every output of a combinational block gets a default first;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      deb_state_nxt = deb_state;
      deb_cnt_nxt   = deb_cnt;
      dir_nxt       = dir_q;
      case (deb_state)
         STABLE: begin
            deb_cnt_nxt = '0;
            if (s_sync != dir_q) begin
               if (deb_cnt == DEB_LAST) begin
                  dir_nxt = s_sync;
               end else begin
                  deb_cnt_nxt   = deb_cnt + 1'b1;
                  deb_state_nxt = CHANGING;
               end
            end
         end
         CHANGING: begin
            if (s_sync == dir_q) begin
               deb_cnt_nxt   = '0;
               deb_state_nxt = STABLE;
            end else if (deb_cnt == DEB_LAST) begin
               dir_nxt       = s_sync;
               deb_cnt_nxt   = '0;
               deb_state_nxt = STABLE;
            end else begin
               deb_cnt_nxt = deb_cnt + 1'b1;
            end
         end
         default: begin
            deb_cnt_nxt   = '0;
            deb_state_nxt = STABLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Count update: load beats tick; limits compare against MAX only.
   // The registered dir is used, so a dir change coinciding with a tick
   // applies from the following tick.
   // ---------------------------------------------------------------
   always_comb begin
      q_nxt  = q;
      tc_nxt = 1'b0;
      if (bus.load) begin
         q_nxt = (bus.din > Q_MAX) ? Q_MAX : bus.din;
      end else if (tick_event) begin
         if (dir_q) begin
            if (q < Q_MAX) begin
               q_nxt = q + 1'b1;
            end else begin
               tc_nxt = 1'b1;
               q_nxt  = SAT ? Q_MAX : '0;
            end
         end else begin
            if (q != '0) begin
               q_nxt = q - 1'b1;
            end else begin
               tc_nxt = 1'b1;
               q_nxt  = SAT ? '0 : Q_MAX;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q    <= '0;
         tc_q <= 1'b0;
      end else begin
         q    <= q_nxt;
         tc_q <= tc_nxt;
      end
   end

   assign bus.q    = q;
   assign bus.tick = tick_q;
   assign bus.tc   = tc_q;
   assign bus.dir  = dir_q;

endmodule

// File: doc/updown_tick_counter.md
# updown_tick_counter

Parametrised successor to the 8-bit 1 Hz up/down counter with switch-selected direction. It generalises width, modulus and tick rate, and adds a terminal-count output. It also adds a wrap/saturate mode, synchronous load, count enable and an on-block synchroniser/debouncer for the direction switch. It sits between the board switches/system clock and the display/LED driver, replacing the fixed 8-bit counter in the top level.

## Interface
- WIDTH, 8, counter width in bits.
- MAX, 255, terminal count; 1 <= MAX <= 2^WIDTH-1. Count range is 0..MAX.
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1, count rate. DIV = CLK_HZ/TICK_HZ must be >= 1.
- SAT, 0, 0 = wrap at limits, 1 = saturate at limits.
- DEB_CYCLES, 1_000_000, number of consecutive stable clocks required to accept a UD change; must be >= 1.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  count enable; low freezes the prescaler and the counter.
- UD  in  1  asynchronous direction switch: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- din  in  WIDTH  load value.
- q  out  WIDTH  count value.
- tick  out  1  one-clock pulse for each prescaler period.
- tc  out  1  one-clock pulse when a tick hits a limit.
- dir  out  1  debounced direction in use.

## Operation
- Reset (asynchronous, any time, including mid-count or mid-debounce) clears all state: q=0, prescaler=0, tick=0, tc=0, dir=0, both synchroniser flops=0, debounce count=0.
- Prescaler: counts 0..DIV-1 while en=1.
  - At DIV-1 it returns to 0 and that cycle is a tick event. tick is a register set on the same edge.
  - With en=0 the prescaler holds and tick=0.
  - With DIV=1 a tick event occurs on every enabled clock.
- UD path:
  - Two-flop synchroniser produces s.
  - Debouncer FSM has two states:
    - STABLE (s==dir): the count is held at 0.
    - CHANGING (s!=dir): the count increments each clock. On the edge where it would reach DEB_CYCLES, dir<=s, the count clears and the FSM returns to STABLE.
  - Any return of s to dir before that edge drops back to STABLE and clears the count.
  - Counter width is clog2(DEB_CYCLES+1).
- Counter update, highest priority first, evaluated on each clock:
  - load=1: q <= min(din, MAX). tc=0. The prescaler is unaffected. tick still pulses if a tick event coincides.
  - Tick event with dir=1:
    - q<MAX: q+1.
    - q==MAX: tc=1, and q becomes 0 (SAT=0) or stays MAX (SAT=1).
  - Tick event with dir=0:
    - q>0: q-1.
    - q==0: tc=1, and q becomes MAX (SAT=0) or stays 0 (SAT=1).
  - Otherwise q holds. In saturate mode tc pulses on every tick spent at the limit.
- A dir change takes effect on the first tick event after the edge that updates dir. A dir update coinciding with a tick edge uses the old dir for that tick.
- All arithmetic is WIDTH-bit and non-overflowing; limits are compared against MAX, never against 2^WIDTH-1 unless MAX equals it.

## Timing
- tick, tc and the new q are all updated on the same edge, which is the edge after the prescaler holds DIV-1. Each output is high for exactly one clock.
- Tick period is exactly DIV enabled clocks. Disabled cycles stretch the period without losing prescaler phase.
- UD latency: a level change held stable reaches dir after 2 + DEB_CYCLES rising edges.
- load latency: q equals the clamped din one edge after load is sampled high.
- Reset deassertion is synchronous to clk in the top level. The first tick occurs DIV enabled clocks after reset release.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
Common parameters: WIDTH=4, MAX=9, CLK_HZ=10, TICK_HZ=1 (DIV=10), DEB_CYCLES=4, SAT=0.
- Reset, en=1, UD=1 held, 100 clocks -> tick every 10 clocks; q steps 0,1..9,0. tc pulses with the tick that changes 9->0.
- Set UD=0 -> dir falls exactly 6 edges later; q then decrements. 0->9 asserts tc.
- UD glitch of 3 clocks (shorter than DEB_CYCLES) -> dir unchanged, debounce count returns to 0.
- SAT=1, up count -> q stops at 9; tc pulses on every following tick; q stays 9.
- load=1, din=15 -> q=9 one edge later. load coinciding with a tick at q=9 -> q=din clamp, tc=0, tick=1.
- en=0 for 7 clocks mid-period, then assert reset mid-period -> q and prescaler freeze during en=0; reset forces every output to 0 immediately, without waiting for a clock.
